// File: rtl/math_mac_pkg.sv
// Shared types and helpers for the math library's multiply-accumulate back ends.
// Holds the accumulator state encoding and signed saturation limit computation.
package math_mac_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} mac_state_t;

    // Most-positive (neg=0) or most-negative (neg=1) two's-complement value of
    // width w, returned in the low w bits of a 64-bit word.
    function automatic logic [63:0] sat_limit(input int unsigned w, input logic neg);
        logic [63:0] max_v;
        max_v = (64'd1 << (w - 1)) - 64'd1;
        return neg ? ~max_v : max_v;
    endfunction

endpackage

// File: rtl/math_adder_signed_saturating.sv
// Combinational W-bit signed adder with overflow flag and optional clamping.
// Overflow: operands share a sign and the raw sum's sign differs from it.
module math_adder_signed_saturating
    import math_mac_pkg::*;
#(
    parameter int W        = 24,
    parameter bit SATURATE = 1'b1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    localparam logic [W-1:0] SAT_MAX = W'(sat_limit(W, 1'b0));
    localparam logic [W-1:0] SAT_MIN = W'(sat_limit(W, 1'b1));

    logic [W-1:0] raw_sum;

    assign raw_sum = a + b;
    assign ovf     = (a[W-1] == b[W-1]) && (raw_sum[W-1] != a[W-1]);

    generate
        if (SATURATE) begin : g_sat
            // On overflow both operands carry the sign the true result would have.
            assign sum = ovf ? (a[W-1] ? SAT_MIN : SAT_MAX) : raw_sum;
        end else begin : g_wrap
            assign sum = raw_sum;
        end
    endgenerate

endmodule

// File: rtl/math_booth_product_accumulator.sv
// Accumulates a stream of signed 2N-bit Booth products into a guarded sum,
// handing the result downstream on a valid/ready handshake after the last beat.
module math_booth_product_accumulator
    import math_mac_pkg::*;
#(
    parameter int N        = 8,
    parameter int GUARD    = 8,
    parameter bit SATURATE = 1'b1,
    parameter int CNT_W    = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_prod_valid,
    output logic                   o_prod_ready,
    input  logic [2*N-1:0]         i_product,
    input  logic                   i_prod_last,
    input  logic                   i_clear,
    output logic                   o_acc_valid,
    input  logic                   i_acc_ready,
    output logic [2*N+GUARD-1:0]   o_acc,
    output logic                   o_acc_ovf,
    output logic [CNT_W-1:0]       o_beat_count,
    output logic                   o_busy
);

    localparam int ACC_W = 2*N + GUARD;

    mac_state_t       state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;
    logic             ready_reg;

    logic             accept;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [CNT_W-1:0] cnt_inc;

    assign accept   = i_prod_valid & ready_reg;
    assign base     = (state_reg == S_ACCUM) ? acc_reg : '0;
    assign prod_ext = ACC_W'($signed(i_product));
    assign cnt_inc  = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);

    math_adder_signed_saturating #(
        .W        (ACC_W),
        .SATURATE (SATURATE)
    ) u_adder (
        .a   (base),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        if (i_clear) begin
            state_next = S_IDLE;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        acc_next   = add_sum;
                        cnt_next   = CNT_W'(1);
                        ovf_next   = add_ovf;
                        state_next = i_prod_last ? S_HOLD : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        acc_next   = add_sum;
                        cnt_next   = cnt_inc;
                        ovf_next   = ovf_reg | add_ovf;
                        state_next = i_prod_last ? S_HOLD : S_ACCUM;
                    end
                end
                S_HOLD: begin
                    if (i_acc_ready) begin
                        state_next = S_IDLE;
                        acc_next   = '0;
                        cnt_next   = '0;
                        ovf_next   = 1'b0;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    acc_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                end
            endcase
        end
    end

    // ready tracks the registered state but stays low throughout reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= S_IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
            ready_reg <= (state_next != S_HOLD);
        end
    end

    assign o_prod_ready = ready_reg;
    assign o_acc_valid  = (state_reg == S_HOLD);
    assign o_acc        = acc_reg;
    assign o_acc_ovf    = ovf_reg;
    assign o_beat_count = cnt_reg;
    assign o_busy       = (state_reg != S_IDLE);

endmodule
